alu_regfile_seq: RTL
====================

Name: alu_regfile_seq

Overview:
- Parametrised, multi-cycle successor to the 16-bit display ALU.
- Accepts one instruction per valid/ready handshake and reads two operands from an internal register bank.
- Executes one of 14 operations, writes the result back, and reports operands, result and flags to the 7-segment display drivers.
- Instructions are strictly serialised, so there are no hazards. Adds shifts, SLT, carry/zero flags, illegal-opcode detection and a debug read port.

Parameters:
- DATA_W, 16: register and result width, must be ≥4.
- NREGS, 16: register count, power of two, ≥2.
- RADDR_W, $clog2(NREGS): register address / immediate field width.
- INSTR_W, 4+3*RADDR_W: instruction width. Derived; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  block can accept an instruction.
- instr  in  INSTR_W  fields: [op 4][rd RADDR_W][rs/imm RADDR_W][rt RADDR_W], MSB first.
- res_valid  out  1  one-cycle pulse: instruction retired.
- res_addr  out  RADDR_W  destination register of the retired instruction.
- res_data  out  DATA_W  result of the retired instruction.
- op_a  out  DATA_W  first operand shown: rs value, or zero-extended imm.
- op_b  out  DATA_W  rt value.
- flag_zero  out  1  last retired result == 0.
- flag_carry  out  1  carry/borrow of the last retired instruction.
- illegal  out  1  pulses with res_valid when the opcode is unsupported.
- busy  out  1  FSM not in IDLE.
- dbg_addr  in  RADDR_W  debug read address.
- dbg_data  out  DATA_W  registered read of dbg_addr.

Behaviour:
- Reset:
  - All registers and all outputs go to 0, and the FSM goes to IDLE.
  - An instruction in flight is aborted with no write-back and no res_valid.
  - instr_ready=0 while reset is high.
- FSM states and transitions:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to READ.
  - READ: register rs and rt values into the operand registers; drive op_a/op_b. Go to EXEC.
  - EXEC: compute the DATA_W result plus carry into the result register. Go to WB.
  - WB: write the register bank at rd (unless illegal); pulse res_valid; update res_addr/res_data/flags; go to IDLE.
- Timing:
  - Latency from handshake cycle N to res_valid is cycle N+3.
  - Next accept is possible at N+4, so throughput is 1 per 4 cycles.
  - instr_valid held high back-to-back is accepted exactly once per IDLE visit.
- Operations (unsigned; imm zero-extended; results truncated to DATA_W):
  - 0 ADD: rd=rs+rt.
  - 1 SUB: rd=rs-rt.
  - 2 AND: rd=rs&rt.
  - 3 SLTI: rd=(rt>imm)?1:0.
  - 4 OR: rd=rs|rt.
  - 5 XOR: rd=rs^rt.
  - 6 ANDI: rd=rt&imm.
  - 7 ORI: rd=rt|imm.
  - 8 XORI: rd=rt^imm.
  - 9 ADDI: rd=rt+imm.
  - A SUBI: rd=rt-imm.
  - B SLT: rd=(rs<rt)?1:0.
  - C SHL: rd=rs<<(rt mod DATA_W).
  - D SHR: rd=rs>>(rt mod DATA_W), logical.
  - E, F: illegal.
- Flags:
  - flag_carry: carry out of bit DATA_W-1 for ADD/ADDI; borrow (minuend<subtrahend) for SUB/SUBI; 0 for all other ops.
  - flag_zero = (res_data==0).
  - Both flags update only in WB and hold otherwise.
- Illegal opcode:
  - No register write; res_data=0; flags unchanged.
  - res_valid and illegal pulse together in WB.
- Register bank:
  - Written only in WB.
  - rd==rs or rd==rt is legal, because operands were captured in READ.
- op_a/op_b hold their value until the next READ.
- Debug port:
  - dbg_data shows dbg_addr one cycle later.
  - A WB write to the same address in the same cycle returns the old value (read-before-write); the new value appears on the next read.

Test Plan:
- Reset, write R1=5 via ADDI (R1=R0+5), then ADDI R2=R0+3, then ADD R3=R1+R2 -> res_valid at handshake+3 with res_addr=3, res_data=8, flag_zero=0, flag_carry=0; dbg_addr=3 reads 8.
- R1=2, SUBI R4=R1-3 -> res_data=0xFFFF, flag_carry=1. Then SUB R5=R4-R4 -> res_data=0, flag_zero=1, flag_carry=0.
- SLTI with R1=5, imm=4 -> result 1; imm=5 -> result 0. SLT R0(0)<R1(5) -> result 1.
- Opcode 0xE with rd=R1 -> illegal=1 and res_valid=1 in the same cycle; R1 unchanged (still 5); flags unchanged from the previous instruction.
- Assert reset in EXEC of ADD R6=R1+R1 -> no res_valid; R6 and R1 read back 0; instr_ready=1 the cycle after reset deasserts.
- DATA_W=8, NREGS=8: ADDI chain to reach R1=0xFF, then ADDI R1=R1+1 -> res_data=0x00, flag_carry=1, flag_zero=1. SHL R2 = R1(0x01)<<9 -> 0x02 (shift by 9 mod 8 = 1).

Source files
------------

// File: rtl/alu_regfile_seq.sv
// Serialised ALU with an internal register bank: IDLE -> READ -> EXEC -> WB, one instruction per four cycles.
// Operands, result and flags are held on registered outputs for the 7-segment display drivers.
module alu_regfile_seq #(
    parameter int  DATA_W  = 16,
    parameter int  NREGS   = 16,
    parameter int  RADDR_W = $clog2(NREGS),
    localparam int INSTR_W = 4 + 3 * RADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               res_valid,
    output logic [RADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0]  res_data,
    output logic [DATA_W-1:0]  op_a,
    output logic [DATA_W-1:0]  op_b,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               illegal,
    output logic               busy,
    input  logic [RADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_SLTI = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ANDI = 4'h6;
    localparam logic [3:0] OP_ORI  = 4'h7;
    localparam logic [3:0] OP_XORI = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_SUBI = 4'hA;
    localparam logic [3:0] OP_SLT  = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;

    // Immediate forms take the middle field as a zero-extended constant instead of rs.
    function automatic logic uses_imm(input logic [3:0] op);
        case (op)
            OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI: uses_imm = 1'b1;
            default:                                            uses_imm = 1'b0;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q;
    logic [DATA_W-1:0]    regs_q [NREGS];
    logic [DATA_W-1:0]    op_a_q, op_b_q;
    logic [DATA_W-1:0]    res_data_q, dbg_data_q;
    logic [RADDR_W-1:0]   res_addr_q;
    logic                 ready_q, busy_q, res_valid_q, illegal_q;
    logic                 flag_zero_q, flag_carry_q;

    logic [3:0]           op_s;
    logic [RADDR_W-1:0]   rd_s, rs_s, rt_s;
    logic [DATA_W:0]      add_s;
    logic [DATA_W-1:0]    shamt_s;
    logic [DATA_W-1:0]    alu_res_s;
    logic                 alu_carry_s, alu_illegal_s;

    assign op_s    = instr_q[INSTR_W-1 -: 4];
    assign rd_s    = instr_q[3*RADDR_W-1 -: RADDR_W];
    assign rs_s    = instr_q[2*RADDR_W-1 -: RADDR_W];
    assign rt_s    = instr_q[RADDR_W-1:0];
    assign add_s   = {1'b0, op_a_q} + {1'b0, op_b_q};
    assign shamt_s = DATA_W'(op_b_q % DATA_W);

    // FSM next-state: strictly serialised, one accept per IDLE visit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid && ready_q) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU: op_a is rs (or imm), op_b is always rt, so immediate forms compute rt OP imm.
    always_comb begin
        alu_res_s     = '0;
        alu_carry_s   = 1'b0;
        alu_illegal_s = 1'b0;
        case (op_s)
            OP_ADD, OP_ADDI: begin
                alu_res_s   = add_s[DATA_W-1:0];
                alu_carry_s = add_s[DATA_W];
            end
            OP_SUB: begin
                alu_res_s   = op_a_q - op_b_q;
                alu_carry_s = (op_a_q < op_b_q);
            end
            OP_SUBI: begin
                alu_res_s   = op_b_q - op_a_q;
                alu_carry_s = (op_b_q < op_a_q);
            end
            OP_AND, OP_ANDI: alu_res_s = op_a_q & op_b_q;
            OP_OR,  OP_ORI:  alu_res_s = op_a_q | op_b_q;
            OP_XOR, OP_XORI: alu_res_s = op_a_q ^ op_b_q;
            OP_SLTI:         alu_res_s = {{(DATA_W-1){1'b0}}, (op_b_q > op_a_q)};
            OP_SLT:          alu_res_s = {{(DATA_W-1){1'b0}}, (op_a_q < op_b_q)};
            OP_SHL:          alu_res_s = op_a_q << shamt_s;
            OP_SHR:          alu_res_s = op_a_q >> shamt_s;
            default: begin
                alu_res_s     = '0;
                alu_illegal_s = 1'b1;
            end
        endcase
    end

    // Control, operand and result registers; results land on the outputs during WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
            res_addr_q   <= '0;
            res_data_q   <= '0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            res_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            if (state_q == S_IDLE && instr_valid && ready_q) begin
                instr_q <= instr;
            end
            if (state_q == S_READ) begin
                op_a_q <= uses_imm(op_s) ? DATA_W'(rs_s) : regs_q[rs_s];
                op_b_q <= regs_q[rt_s];
            end
            if (state_q == S_EXEC) begin
                res_valid_q <= 1'b1;
                illegal_q   <= alu_illegal_s;
                res_addr_q  <= rd_s;
                res_data_q  <= alu_res_s;
                if (!alu_illegal_s) begin
                    flag_carry_q <= alu_carry_s;
                    flag_zero_q  <= (alu_res_s == '0);
                end
            end
        end
    end

    // Register bank and debug read; a same-cycle WB write is seen by the next debug read only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            dbg_data_q <= '0;
        end else begin
            dbg_data_q <= regs_q[dbg_addr];
            if (state_q == S_WB && !illegal_q) begin
                regs_q[res_addr_q] <= res_data_q;
            end
        end
    end

    assign instr_ready = ready_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign illegal     = illegal_q;
    assign res_addr    = res_addr_q;
    assign res_data    = res_data_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign flag_zero   = flag_zero_q;
    assign flag_carry  = flag_carry_q;
    assign dbg_data    = dbg_data_q;

endmodule
